// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encoding and mode constants for the bit-serial adder/subtractor
package serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/serial_addsub_cell.sv
// addsub_cell: one-bit full adder or full subtractor selected by mode
module addsub_cell
  import serial_addsub_pkg::*;
(
  input  logic ai,
  input  logic bi,
  input  logic chain_in,
  input  logic mode,
  output logic res_bit,
  output logic chain_out
);
  assign res_bit = ai ^ bi ^ chain_in;
  assign chain_out = mode == MODE_SUB ? (~ai & bi) | (chain_in & ~(ai ^ bi))
                                      : (ai & bi) | (chain_in & (ai ^ bi));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one bit per clock LSB first, start/busy/done handshake
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, nxt;
  logic [WIDTH-1:0] sa, sb, acc, nxt_acc;
  logic [CW-1:0] cnt;
  logic md, chain, res_bit, chain_out, last, accept;
  addsub_cell u_cell (
    .ai(sa[0]),
    .bi(sb[0]),
    .chain_in(chain),
    .mode(md),
    .res_bit(res_bit),
    .chain_out(chain_out)
  );
  always_comb begin
    accept = start && state != RUN;
    last = cnt == CW'(WIDTH - 1);
    nxt = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    // shift-based MSB insert keeps WIDTH=1 free of empty slices
    nxt_acc = (acc >> 1) | (WIDTH'(res_bit) << (WIDTH - 1));
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sa <= '0;
      sb <= '0;
      acc <= '0;
      md <= 1'b0;
      chain <= 1'b0;
      result <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        sa <= a;
        sb <= b;
        md <= mode;
        chain <= cin;
        cnt <= '0;
      end else if (state == RUN) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        chain <= chain_out;
        acc <= nxt_acc;
        cnt <= cnt + CW'(1);
        if (last) begin
          result <= nxt_acc;
          cout <= chain_out;
          ovf <= chain ^ chain_out;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for serial_addsub at WIDTH=8 (directed + random) and WIDTH=3 (exhaustive)
module tb_serial_addsub;
  typedef struct packed {logic v; logic c; logic [7:0] r;} exp_t;
  logic clk, rst_n;
  logic start8, mode8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, res8;
  logic start3, mode3, cin3, busy3, done3, cout3, ovf3;
  logic [2:0] a3, b3, res3;
  exp_t q8[$];
  exp_t q3[$];
  int passed = 0, total = 0;
  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
  );
  serial_addsub #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .result(res3), .cout(cout3), .ovf(ovf3)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
  endtask
  function automatic exp_t model(input int w, input logic m, input int x, input int y, input logic ci);
    int full, mask;
    logic sx, sy, sr;
    exp_t e;
    mask = (1 << w) - 1;
    full = m ? x - y - int'(ci) : x + y + int'(ci);
    e.r = 8'(full & mask);
    e.c = m ? (full < 0) : (full > mask);
    sx = 1'((x >> (w - 1)) & 1);
    sy = 1'((y >> (w - 1)) & 1);
    sr = 1'(((full & mask) >> (w - 1)) & 1);
    e.v = m ? (sx != sy && sr != sx) : (sx == sy && sr != sx);
    return e;
  endfunction
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        total++;
        $display("FAIL unexpected_done8: done with empty scoreboard at %0t", $time);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("res8", res8, e.r);
        chk("cout8", cout8, e.c);
        chk("ovf8", ovf8, e.v);
      end
    end
    if (done3) begin
      if (q3.size() == 0) begin
        total++;
        $display("FAIL unexpected_done3: done with empty scoreboard at %0t", $time);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("res3", res3, int'(e.r[2:0]));
        chk("cout3", cout3, e.c);
        chk("ovf3", ovf3, e.v);
      end
    end
  end
  // called at a negedge; returns at the negedge where done is seen
  task automatic op8(input logic m, input logic [7:0] x, input logic [7:0] y, input logic ci,
                     input exp_t e, output int edges, output int bcyc);
    q8.push_back(e);
    mode8 = m; a8 = x; b8 = y; cin8 = ci; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    edges = 1;
    bcyc = 0;
    while (!done8 && edges < 40) begin
      bcyc += int'(busy8);
      @(negedge clk);
      edges++;
    end
    if (!done8) chk("timeout8", 0, 1);
  endtask
  task automatic op3(input logic m, input logic [2:0] x, input logic [2:0] y, input logic ci, input exp_t e);
    int edges;
    q3.push_back(e);
    mode3 = m; a3 = x; b3 = y; cin3 = ci; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    edges = 1;
    while (!done3 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    if (!done3) chk("timeout3", 0, 1);
  endtask
  initial begin
    int ed, bc, k;
    rst_n = 1'b0;
    {start8, mode8, cin8, a8, b8} = '0;
    {start3, mode3, cin3, a3, b3} = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_result", res8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_ovf", ovf8, 0);
    rst_n = 1'b1;
    @(negedge clk);
    op8(1'b1, 8'h35, 8'h12, 1'b0, {1'b0, 1'b0, 8'h23}, ed, bc);
    chk("lat_edges", ed, 9);
    chk("busy_cycles", bc, 8);
    op8(1'b1, 8'h12, 8'h35, 1'b0, {1'b0, 1'b1, 8'hDD}, ed, bc);
    op8(1'b1, 8'h80, 8'h01, 1'b0, {1'b1, 1'b0, 8'h7F}, ed, bc);
    op8(1'b0, 8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00}, ed, bc);
    op8(1'b0, 8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80}, ed, bc);
    op8(1'b1, 8'h00, 8'h00, 1'b1, {1'b0, 1'b1, 8'hFF}, ed, bc);
    op8(1'b0, 8'h01, 8'h02, 1'b0, {1'b0, 1'b0, 8'h03}, ed, bc);
    chk("b2b_lat_edges", ed, 9);
    @(negedge clk);
    // start pulse and operand changes during RUN must be ignored
    q8.push_back({1'b0, 1'b0, 8'h23});
    mode8 = 1'b1; a8 = 8'h35; b8 = 8'h12; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; mode8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    while (!done8 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!done8) chk("timeout_ignore", 0, 1);
    repeat (12) @(negedge clk);
    // reset at E4 aborts the operation
    mode8 = 1'b1; a8 = 8'h35; b8 = 8'h12; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_result", res8, 0);
    chk("abort_cout", cout8, 0);
    chk("abort_ovf", ovf8, 0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    op8(1'b0, 8'h10, 8'h22, 1'b1, {1'b0, 1'b0, 8'h33}, ed, bc);
    chk("post_rst_lat", ed, 9);
    for (int i = 0; i < 1000; i++) begin
      logic m, ci;
      logic [7:0] x, y;
      m = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      op8(m, x, y, ci, model(8, m, int'(x), int'(y), ci), ed, bc);
    end
    @(negedge clk);
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++)
          for (int ci = 0; ci < 2; ci++)
            op3(1'(m), 3'(x), 3'(y), 1'(ci), model(3, 1'(m), x, y, 1'(ci)));
    repeat (4) @(negedge clk);
    chk("drain8", q8.size(), 0);
    chk("drain3", q3.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor. It is the sequential successor to the team's one-bit full-subtractor cell.
- It processes one bit per clock, LSB first, through a single add/sub cell, with a start/busy/done handshake.
- It generalises the cell in operand width and adds an add/sub mode, carry/borrow chaining and a signed-overflow flag.
- It sits in the arithmetic datapath library, where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 1.

Ports:
- clk  input  1  single clock; all logic updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- mode  input  1  0 = add (a+b+cin), 1 = subtract (a-b-cin); captured at start.
- a  input  WIDTH  minuend/augend; captured at start.
- b  input  WIDTH  subtrahend/addend; captured at start.
- cin  input  1  carry-in (add) or borrow-in (sub); captured at start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid from this cycle.
- result  output  WIDTH  sum/difference; held until the next accepted start.
- cout  output  1  carry-out (add) or borrow-out (sub) of the MSB.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: on any edge where rst_n=0, go to IDLE. busy=0, done=0, result=0, cout=0, ovf=0, bit counter=0. Reset mid-operation discards the operation and no done is produced.
- States are IDLE, RUN and DONE.
- IDLE: start=1 at edge E0 captures a, b, mode and cin into shift registers and the chain bit, clears the counter and enters RUN.
- RUN: edges E1..E(WIDTH) each process bit i=count.
  - add: s=ai^bi^c; c'=ai&bi | c&(ai^bi).
  - sub: d=ai^bi^br; br'=~ai&bi | br&~(ai^bi).
  - The result bit shifts in at the MSB of the result register.
  - The chain bit entering the MSB is saved for the overflow calculation.
  - At E(WIDTH): cout=final chain bit, ovf=(chain into MSB) XOR (chain out of MSB), state goes to DONE.
- busy=1 in exactly the WIDTH cycles following E0, i.e. while the state is RUN.
- start during RUN is ignored. Changes to a, b, mode or cin during RUN have no effect.
- DONE: done=1 for exactly one cycle, the cycle after E(WIDTH). Latency from the start edge to done is WIDTH+1 edges.
  - result, cout and ovf are valid in this cycle and stay stable in IDLE until the next accepted start.
  - start=1 while in DONE is accepted exactly as in IDLE (back-to-back operation, new RUN next cycle). Otherwise the state returns to IDLE.
- Outputs result, cout and ovf update only at E(WIDTH) and at reset. Partial shifting is internal only.
- WIDTH=1: one RUN cycle; ovf = cin-chain XOR cout.
- All arithmetic is modulo 2^WIDTH. cout reports the unsigned carry or borrow; ovf reports the signed condition.
- Counter width is $clog2(WIDTH+1). No combinational path from inputs to outputs.

Decomposition:
- Package serial_addsub_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
- One natural combinational sub-module, addsub_cell:
  - inputs ai, bi, chain_in, mode;
  - outputs res_bit, chain_out;
  - the one-bit full adder/full subtractor selected by mode.
- The top level contains the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=8, sub, a=8'h35, b=8'h12, cin=0 -> result=8'h23, cout=0, ovf=0. done pulses exactly 9 edges after the start edge; busy high for 8 cycles.
- sub a=8'h12, b=8'h35, cin=0 -> result=8'hDD, cout=1 (borrow), ovf=0. Then sub a=8'h80, b=8'h01 -> result=8'h7F, cout=0, ovf=1.
- add a=8'hFF, b=8'h01, cin=0 -> result=8'h00, cout=1, ovf=0. Then add a=8'h7F, b=8'h01 -> result=8'h80, cout=0, ovf=1.
- sub a=8'h00, b=8'h00, cin=1 -> result=8'hFF, cout=1, ovf=0. Also issue start again in the DONE cycle with add 8'h01+8'h02 -> next done 9 edges later, result=8'h03.
- Start sub 8'h35-8'h12, then:
  - pulse start and change a to 8'hAA during RUN -> ignored, result still 8'h23;
  - separately, drive rst_n=0 at E4 -> all outputs 0 next cycle, no done, a subsequent start works normally.
- Randomised sweep of 1000 operations at WIDTH=8 plus an exhaustive sweep at WIDTH=3 (all a, b, cin, mode) against a reference model:
  - result = (a±b±cin) mod 2^WIDTH;
  - cout = unsigned carry/borrow;
  - ovf = signed overflow.
